// File: rtl/perf_counter_bank_pkg.sv
// Shared constants for the performance counter bank: widths and the event index map,
// also used by the bench when dumping metrics.
package perf_counter_bank_pkg;

   localparam int unsigned CNT_W   = 64;
   localparam int unsigned NUM_CNT = 8;
   localparam int unsigned IDX_W   = 3;

   localparam int unsigned CNT_CYCLE   = 0;
   localparam int unsigned CNT_INSTRET = 1;
   localparam int unsigned CNT_STALL   = 2;
   localparam int unsigned CNT_FLUSH   = 3;
   localparam int unsigned CNT_BRANCH  = 4;
   localparam int unsigned CNT_MISPRED = 5;
   localparam int unsigned CNT_LOAD    = 6;
   localparam int unsigned CNT_STORE   = 7;

endpackage

// File: rtl/perf_counter_bank_sat_counter.sv
// Saturating event counter with sticky overflow flag and synchronous clear.
// o_q_next is the post-increment, pre-clear value, used by the parent for snapshots.
module perf_sat_counter #(
   parameter int unsigned CNT_W = 64
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_inc,
   input  logic             i_clr,
   output logic [CNT_W-1:0] o_q_next,
   output logic             o_ovf
);

   logic [CNT_W-1:0] r_q;
   logic             r_ovf;
   logic             w_sat;

   assign w_sat    = &r_q;
   assign o_q_next = w_sat ? r_q : r_q + {{(CNT_W-1){1'b0}}, i_inc};
   assign o_ovf    = r_ovf;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_q   <= '0;
         r_ovf <= 1'b0;
      end else if (i_clr) begin
         r_q   <= '0;
         r_ovf <= 1'b0;
      end else begin
         r_q <= o_q_next;
         if (w_sat && i_inc) begin
            r_ovf <= 1'b1;
         end
      end
   end

endmodule

// File: rtl/perf_counter_bank.sv
// Bank of gated saturating event counters with atomic shadow snapshot and a
// registered indexed read port over the shadow copy.
module perf_counter_bank
   import perf_counter_bank_pkg::*;
#(
   parameter int unsigned CNT_W = perf_counter_bank_pkg::CNT_W
) (
   input  logic               i_clk,
   input  logic               i_rst,
   input  logic               i_test_enable,
   input  logic               i_retire_valid,
   input  logic               i_stall,
   input  logic               i_flush,
   input  logic               i_branch_valid,
   input  logic               i_branch_mispred,
   input  logic               i_load_valid,
   input  logic               i_store_valid,
   input  logic               i_clear_req,
   input  logic               i_snap_req,
   input  logic [IDX_W-1:0]   i_rd_idx,
   output logic [CNT_W-1:0]   o_rd_data,
   output logic               o_snap_valid,
   output logic [NUM_CNT-1:0] o_ovf
);

   logic [NUM_CNT-1:0] w_event;
   logic [NUM_CNT-1:0] w_inc;
   logic [CNT_W-1:0]   w_q_next [NUM_CNT];
   logic [CNT_W-1:0]   r_shadow [NUM_CNT];
   logic [CNT_W-1:0]   r_rd_data;
   logic               r_snap_valid;

   always_comb begin
      w_event              = '0;
      w_event[CNT_CYCLE]   = 1'b1;
      w_event[CNT_INSTRET] = i_retire_valid;
      w_event[CNT_STALL]   = i_stall;
      w_event[CNT_FLUSH]   = i_flush;
      w_event[CNT_BRANCH]  = i_branch_valid;
      w_event[CNT_MISPRED] = i_branch_valid & i_branch_mispred;
      w_event[CNT_LOAD]    = i_load_valid;
      w_event[CNT_STORE]   = i_store_valid;
   end

   assign w_inc = w_event & {NUM_CNT{i_test_enable}};

   for (genvar g = 0; g < NUM_CNT; g++) begin : g_cnt
      perf_sat_counter #(
         .CNT_W (CNT_W)
      ) u_cnt (
         .i_clk    (i_clk),
         .i_rst    (i_rst),
         .i_inc    (w_inc[g]),
         .i_clr    (i_clear_req),
         .o_q_next (w_q_next[g]),
         .o_ovf    (o_ovf[g])
      );
   end

   // Shadow captures the pre-clear value, so clear+snap in one cycle loses nothing.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         for (int i = 0; i < NUM_CNT; i++) begin
            r_shadow[i] <= '0;
         end
         r_rd_data    <= '0;
         r_snap_valid <= 1'b0;
      end else begin
         if (i_snap_req) begin
            for (int i = 0; i < NUM_CNT; i++) begin
               r_shadow[i] <= w_q_next[i];
            end
         end
         r_rd_data    <= r_shadow[i_rd_idx];
         r_snap_valid <= r_snap_valid | i_snap_req;
      end
   end

   assign o_rd_data    = r_rd_data;
   assign o_snap_valid = r_snap_valid;

endmodule
